// File: rtl/fxp2float_s.sv
//----------------------------------------------------------------------------
// fxp2float_s : 3-stage signed fixed-point to IEEE-754 fp32 converter (abs / lzc / pack).
// Optional output-transfer counter cnt_o when FXP2FLOAT_CNT_EN is defined.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fxp2float_s #(
  parameter int FXP_W  = 16,
  parameter int FRAC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FXP_W-1:0] fxp_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      fp32_o
`ifdef FXP2FLOAT_CNT_EN
  ,
  output logic [31:0]      cnt_o
`endif
);

  localparam int          PW         = $clog2(FXP_W);
  localparam logic [7:0]  C_EXP_BIAS = 8'(127 - FRAC_W);

  logic             w_adv;
  logic [FXP_W-1:0] w_mag;
  logic [PW-1:0]    w_p;
  logic             w_zero;
  logic [4:0]       w_sh;
  logic [7:0]       w_exp;
  logic [22:0]      w_man;
  logic [31:0]      w_pack;

  logic             r_s1_v;
  logic             r_s1_sign;
  logic [FXP_W-1:0] r_s1_mag;

  logic             r_s2_v;
  logic             r_s2_sign;
  logic             r_s2_zero;
  logic [FXP_W-1:0] r_s2_mag;
  logic [PW-1:0]    r_s2_p;

  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  // Unsigned magnitude is FXP_W wide, so the most-negative input maps to 2^(FXP_W-1).
  assign w_mag = fxp_i[FXP_W-1] ? -fxp_i : fxp_i;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < FXP_W; i++) begin
      if (r_s1_mag[i]) w_p = PW'(i);
    end
  end

  assign w_zero = (r_s1_mag == '0);

  // Shift the leading one to bit 23 and drop it; the remaining bits are the mantissa.
  assign w_sh   = 5'd23 - 5'(r_s2_p);
  assign w_man  = 23'(24'(r_s2_mag) << w_sh);
  assign w_exp  = C_EXP_BIAS + 8'(r_s2_p);
  assign w_pack = r_s2_zero ? 32'h0000_0000 : {r_s2_sign, w_exp, w_man};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_mag  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_mag  <= '0;
      r_s2_p    <= '0;
      out_valid <= 1'b0;
      fp32_o    <= 32'h0000_0000;
    end else if (w_adv) begin
      r_s1_v    <= in_valid;
      r_s1_sign <= fxp_i[FXP_W-1];
      r_s1_mag  <= w_mag;
      r_s2_v    <= r_s1_v;
      r_s2_sign <= r_s1_sign;
      r_s2_zero <= w_zero;
      r_s2_mag  <= r_s1_mag;
      r_s2_p    <= w_p;
      out_valid <= r_s2_v;
      fp32_o    <= w_pack;
    end
  end

`ifdef FXP2FLOAT_CNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 32'h0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + 32'h1;
    end
  end

  assign cnt_o = r_cnt;
`endif

endmodule

`default_nettype wire
